// File: rtl/mandelbrot_pkg.sv
// Shared FSM encoding and fixed-point helpers for the escape-time engine.
// Fixed-point format is signed 2.(w-2); squared quantities carry 2*(w-2) fraction bits.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int fx_one(input int w);
        return 1 << (w - 2);
    endfunction

    // |z|^2 threshold of 4.0 expressed with the doubled fraction of a square
    function automatic int fx_four_sq(input int w);
        return 4 * fx_one(w) * fx_one(w);
    endfunction

    function automatic int fx_max(input int w);
        return 2 * fx_one(w) - 1;
    endfunction

    function automatic int fx_min(input int w);
        return -2 * fx_one(w);
    endfunction

endpackage

// File: rtl/mandelbrot_iter_engine_if.sv
// Request/response bundle between pixel scanner, iteration engine and colour mapper.
// master = producer of points / consumer of results, slave = the engine.
interface mandelbrot_iter_engine_if #(
    parameter int WIDTH      = 8,
    parameter int ITER_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_pr;
    logic signed [WIDTH-1:0] in_pi;
    logic                    in_julia;
    logic signed [WIDTH-1:0] julia_cr;
    logic signed [WIDTH-1:0] julia_ci;
    logic [ITER_WIDTH-1:0]   max_iter;
    logic                    out_valid;
    logic                    out_ready;
    logic [ITER_WIDTH-1:0]   out_iter;
    logic                    out_escaped;
    logic                    out_overflow;

    modport master (
        output in_valid, in_pr, in_pi, in_julia, julia_cr, julia_ci, max_iter, out_ready,
        input  in_ready, out_valid, out_iter, out_escaped, out_overflow
    );

    modport slave (
        input  in_valid, in_pr, in_pi, in_julia, julia_cr, julia_ci, max_iter, out_ready,
        output in_ready, out_valid, out_iter, out_escaped, out_overflow
    );

endinterface

// File: rtl/mandelbrot_step.sv
// One combinational z <= z^2 + c step with escape (|z|^2 > 4) and range-overflow flags.
// Products are kept exact in a 2*WIDTH+2 bit signed domain, then floored back to 2.(WIDTH-2).
module mandelbrot_step
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH-1:0] zr,
    input  logic signed [WIDTH-1:0] zi,
    input  logic signed [WIDTH-1:0] cr,
    input  logic signed [WIDTH-1:0] ci,
    output logic signed [WIDTH-1:0] nzr,
    output logic signed [WIDTH-1:0] nzi,
    output logic                    size_gt4,
    output logic                    overflow
);

    localparam int FRAC = WIDTH - 2;

    typedef logic signed [2*WIDTH+1:0] wide_t;
    typedef logic        [2*WIDTH:0]   size_t;

    localparam wide_t MAX_V   = wide_t'(fx_max(WIDTH));
    localparam wide_t MIN_V   = wide_t'(fx_min(WIDTH));
    localparam size_t FOUR_SQ = size_t'(fx_four_sq(WIDTH));

    wide_t zr_w, zi_w, zr_sq, zi_sq;
    wide_t re_full, im_full, re_q, im_q;
    size_t size;

    always_comb begin
        zr_w     = wide_t'(zr);
        zi_w     = wide_t'(zi);
        zr_sq    = zr_w * zr_w;
        zi_sq    = zi_w * zi_w;
        // both squares are non-negative, so the sum is safely reinterpreted unsigned
        size     = size_t'(zr_sq + zi_sq);
        size_gt4 = (size > FOUR_SQ);

        re_full  = zr_sq - zi_sq + (wide_t'(cr) <<< FRAC);
        im_full  = ((zr_w * zi_w) <<< 1) + (wide_t'(ci) <<< FRAC);
        re_q     = re_full >>> FRAC;
        im_q     = im_full >>> FRAC;

        overflow = (re_q > MAX_V) || (re_q < MIN_V) ||
                   (im_q > MAX_V) || (im_q < MIN_V);
        nzr      = re_q[WIDTH-1:0];
        nzi      = im_q[WIDTH-1:0];
    end

endmodule

// File: rtl/mandelbrot_iter_engine.sv
// Sequential escape-time engine: one accepted point, one z^2+c step per clock, result held
// until the consumer takes it. Supports Mandelbrot (z0=0, c=pixel) and Julia (z0=pixel) modes.
module mandelbrot_iter_engine
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ITER_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mandelbrot_iter_engine_if.slave  bus
);

    state_e state, state_nxt;

    logic signed [WIDTH-1:0] zr, zi, cr, ci;
    logic [ITER_WIDTH-1:0]   k, lim;
    logic [ITER_WIDTH-1:0]   res_iter;
    logic                    res_escaped, res_overflow;

    logic signed [WIDTH-1:0] nzr, nzi;
    logic                    size_gt4, step_ovf;
    logic [ITER_WIDTH-1:0]   k_inc;

    logic                    accept, advance, finish;
    logic [ITER_WIDTH-1:0]   fin_iter;
    logic                    fin_escaped, fin_overflow;

    mandelbrot_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .zr       (zr),
        .zi       (zi),
        .cr       (cr),
        .ci       (ci),
        .nzr      (nzr),
        .nzi      (nzi),
        .size_gt4 (size_gt4),
        .overflow (step_ovf)
    );

    assign k_inc = k + ITER_WIDTH'(1);

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        advance      = 1'b0;
        finish       = 1'b0;
        fin_iter     = '0;
        fin_escaped  = 1'b0;
        fin_overflow = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (bus.max_iter == '0) begin
                        state_nxt = S_DONE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = S_ITER;
                    end
                end
            end
            S_ITER: begin
                // escape on size outranks overflow of the step that would follow it
                if (size_gt4) begin
                    state_nxt   = S_DONE;
                    finish      = 1'b1;
                    fin_iter    = k;
                    fin_escaped = 1'b1;
                end else if (step_ovf) begin
                    state_nxt    = S_DONE;
                    finish       = 1'b1;
                    fin_iter     = k;
                    fin_escaped  = 1'b1;
                    fin_overflow = 1'b1;
                end else if (k_inc == lim) begin
                    state_nxt = S_DONE;
                    finish    = 1'b1;
                    fin_iter  = lim;
                end else begin
                    advance = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            zr           <= '0;
            zi           <= '0;
            cr           <= '0;
            ci           <= '0;
            k            <= '0;
            lim          <= '0;
            res_iter     <= '0;
            res_escaped  <= 1'b0;
            res_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                k   <= '0;
                lim <= bus.max_iter;
                if (bus.in_julia) begin
                    zr <= bus.in_pr;
                    zi <= bus.in_pi;
                    cr <= bus.julia_cr;
                    ci <= bus.julia_ci;
                end else begin
                    zr <= '0;
                    zi <= '0;
                    cr <= bus.in_pr;
                    ci <= bus.in_pi;
                end
            end
            if (advance) begin
                zr <= nzr;
                zi <= nzi;
                k  <= k_inc;
            end
            if (finish) begin
                res_iter     <= fin_iter;
                res_escaped  <= fin_escaped;
                res_overflow <= fin_overflow;
            end
        end
    end

    assign bus.in_ready     = (state == S_IDLE);
    assign bus.out_valid    = (state == S_DONE);
    assign bus.out_iter     = res_iter;
    assign bus.out_escaped  = res_escaped;
    assign bus.out_overflow = res_overflow;

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Randomised bench for mandelbrot_iter_engine with an integer escape-time model.
module tb_mandelbrot_iter_engine;

    localparam int W  = 8;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mandelbrot_iter_engine_if #(.WIDTH(W), .ITER_WIDTH(IW)) bus ();

    mandelbrot_iter_engine #(.WIDTH(W), .ITER_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int exp_iter = 0;
    bit exp_esc  = 1'b0;
    bit exp_ovf  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Escape-time reference: plain integer arithmetic, 1.0 = 64.
    function automatic void model(input int pr, input int pi, input bit jul,
                                  input int jcr, input int jci, input int mi,
                                  output int it, output bit esc, output bit ovf);
        int zr, zi, cr, ci, nr, ni;
        it = 0; esc = 1'b0; ovf = 1'b0;
        if (jul) begin
            zr = pr; zi = pi; cr = jcr; ci = jci;
        end else begin
            zr = 0; zi = 0; cr = pr; ci = pi;
        end
        if (mi == 0) return;
        for (int k = 0; k < mi; k++) begin
            if (zr * zr + zi * zi > 4 * 64 * 64) begin
                it = k; esc = 1'b1; return;
            end
            nr = (zr * zr - zi * zi + cr * 64) >>> 6;
            ni = (2 * zr * zi + ci * 64) >>> 6;
            if (nr < -128 || nr > 127 || ni < -128 || ni > 127) begin
                it = k; esc = 1'b1; ovf = 1'b1; return;
            end
            zr = nr; zi = ni;
        end
        it = mi;
    endfunction

    // Result checker: every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            check("out_iter", int'(bus.out_iter), exp_iter);
            check("out_escaped", int'(bus.out_escaped), int'(exp_esc));
            check("out_overflow", int'(bus.out_overflow), int'(exp_ovf));
            check("in_ready_in_done", int'(bus.in_ready), 0);
        end
    end

    task automatic randomize_inputs();
        bus.in_pr    = W'($urandom);
        bus.in_pi    = W'($urandom);
        bus.in_julia = 1'($urandom);
        bus.julia_cr = W'($urandom);
        bus.julia_ci = W'($urandom);
        bus.max_iter = IW'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_point(input logic signed [W-1:0] pr, input logic signed [W-1:0] pi,
                             input bit jul, input logic signed [W-1:0] jcr,
                             input logic signed [W-1:0] jci, input logic [IW-1:0] mi,
                             input int hold, input string tag);
        int it, lat, exp_lat;
        bit esc, ovf;
        model(pr, pi, jul, jcr, jci, int'(mi), it, esc, ovf);
        exp_iter = it; exp_esc = esc; exp_ovf = ovf;
        // samples are taken at negedges; index 1 is the first negedge after the accept edge
        exp_lat = (mi == 0) ? 1 : (esc ? it + 2 : int'(mi) + 1);

        @(negedge clk);
        check({tag, "_in_ready_idle"}, int'(bus.in_ready), 1);
        bus.in_pr = pr; bus.in_pi = pi; bus.in_julia = jul;
        bus.julia_cr = jcr; bus.julia_ci = jci; bus.max_iter = mi;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        randomize_inputs();

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 400);
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, lat, exp_lat);
            do_reset();
            return;
        end
        check({tag, "_latency"}, lat, exp_lat);

        for (int h = 0; h < hold; h++) begin
            randomize_inputs();
            bus.in_valid = 1'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"}, int'(bus.out_valid), 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_release_valid"}, int'(bus.out_valid), 0);
        check({tag, "_release_ready"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int it;
        bit esc, ovf;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        randomize_inputs();

        // pin the model with hand-derived results
        model(0, 0, 1'b0, 0, 0, 16, it, esc, ovf);
        check("model_c0", it * 4 + int'(esc) * 2 + int'(ovf), 16 * 4);
        model(32, 32, 1'b0, 0, 0, 50, it, esc, ovf);
        check("model_c05", it * 4 + int'(esc) * 2 + int'(ovf), 4 * 4 + 3);
        model(96, 0, 1'b1, 0, 0, 50, it, esc, ovf);
        check("model_julia15", it * 4 + int'(esc) * 2 + int'(ovf), 3);
        model(-64, 0, 1'b0, 0, 0, 255, it, esc, ovf);
        check("model_cm1", it * 4 + int'(esc) * 2 + int'(ovf), 255 * 4);
        model(-64, 0, 1'b0, 0, 0, 0, it, esc, ovf);
        check("model_max0", it * 4 + int'(esc) * 2 + int'(ovf), 0);

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_iter", int'(bus.out_iter), 0);
        check("rst_out_escaped", int'(bus.out_escaped), 0);
        check("rst_out_overflow", int'(bus.out_overflow), 0);
        rst_n = 1'b1;

        run_point(8'sd0, 8'sd0, 1'b0, 8'sd0, 8'sd0, 8'd16, 0, "c0");
        run_point(8'sd32, 8'sd32, 1'b0, 8'sd0, 8'sd0, 8'd50, 2, "c05");
        run_point(8'sd96, 8'sd0, 1'b1, 8'sd0, 8'sd0, 8'd50, 1, "julia15");
        run_point(-8'sd64, 8'sd0, 1'b0, 8'sd0, 8'sd0, 8'd0, 0, "max0");
        run_point(8'sd0, 8'sd0, 1'b0, 8'sd0, 8'sd0, 8'd1, 0, "max1");
        run_point(8'sd127, -8'sd128, 1'b1, 8'sd5, -8'sd7, 8'd9, 10, "backpressure");
        run_point(-8'sd64, 8'sd0, 1'b0, 8'sd0, 8'sd0, 8'd255, 0, "max255");

        // reset in the middle of a long iteration
        exp_iter = 0; exp_esc = 1'b0; exp_ovf = 1'b0;
        @(negedge clk);
        bus.in_pr = 8'sd0; bus.in_pi = 8'sd0; bus.in_julia = 1'b0; bus.max_iter = 8'd200;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int i = 0; i < 50; i++) @(negedge clk);
        check("mid_iter_busy", int'(bus.in_ready), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_iter", int'(bus.out_iter), 0);
        check("midrst_out_escaped", int'(bus.out_escaped), 0);
        check("midrst_out_overflow", int'(bus.out_overflow), 0);
        rst_n = 1'b1;

        for (int n = 0; n < 60; n++) begin
            logic signed [W-1:0] rpr, rpi, rcr, rci;
            logic [IW-1:0] rmi;
            rpr = W'($urandom); rpi = W'($urandom);
            rcr = W'($urandom_range(0, 160) - 80);
            rci = W'($urandom_range(0, 160) - 80);
            rmi = IW'($urandom_range(0, 40));
            if (n % 3 == 0) begin
                rpr = W'($urandom_range(0, 160) - 100);
                rpi = W'($urandom_range(0, 100) - 50);
            end
            run_point(rpr, rpi, 1'($urandom), rcr, rci, rmi, $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
